// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo definitions: default tag/result widths, the reserved invalid tag,
// and the {c,v,z,n} condition-flag layout used by every reservation station.
package cdb_arbiter_pkg;

    localparam int unsigned TOMA_TAG_W  = 5;
    localparam int unsigned TOMA_DATA_W = 32;
    localparam int unsigned TOMA_ICC_W  = 4;

    localparam logic [TOMA_TAG_W-1:0] INVALID_TAG = '1;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } icc_t;

endpackage

// File: rtl/cdb_port_fifo.sv
// Single-port synchronous FIFO holding queued CDB results for one producer.
module cdb_port_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-producer result FIFOs, round-robin pop of one
// entry per cycle, registered broadcast of tag/value/flags.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned TAG_W      = TOMA_TAG_W,
    parameter int unsigned DATA_W     = TOMA_DATA_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*TAG_W-1:0]    in_tag,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_val,
    input  logic [NUM_PORTS*4-1:0]        in_icc,
    output logic [NUM_PORTS-1:0]          out_ready,
    output logic                          out_CDB_broadcast,
    output logic [TAG_W-1:0]              out_CDB_tag,
    output logic [DATA_W-1:0]             out_CDB_val,
    output logic [3:0]                    out_ICC_flags,
    output logic                          out_drop_err
);

    localparam int unsigned PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned ENTRY_W = TAG_W + DATA_W + TOMA_ICC_W;
    // All-ones reserved tag, sized to this instance's TAG_W.
    localparam logic [TAG_W-1:0] INV_TAG = '1;

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] drop;
    logic [ENTRY_W-1:0]   pop_data [NUM_PORTS];

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 gnt_valid;
    logic [ENTRY_W-1:0]   sel_entry;
    icc_t                 icc_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic tag_bad;
        assign tag_bad = (in_tag[p*TAG_W +: TAG_W] == INV_TAG);
        assign push[p] = in_valid[p] && !full[p] && !tag_bad;
        assign drop[p] = in_valid[p] && !full[p] && tag_bad;

        cdb_port_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[p]),
            .push_data ({in_tag[p*TAG_W +: TAG_W], in_val[p*DATA_W +: DATA_W], in_icc[p*4 +: 4]}),
            .pop       (pop[p]),
            .pop_data  (pop_data[p]),
            .full      (full[p]),
            .empty     (empty[p])
        );
    end

    assign out_ready = ~full;

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_PORTS;
            if (!gnt_valid && !empty[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    assign pop       = gnt_valid ? (NUM_PORTS'(1) << gnt_idx) : '0;
    assign sel_entry = pop_data[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr            <= '0;
            out_CDB_broadcast <= 1'b0;
            out_CDB_tag       <= '0;
            out_CDB_val       <= '0;
            icc_q             <= '0;
            out_drop_err      <= 1'b0;
        end else begin
            out_CDB_broadcast <= gnt_valid;
            if (gnt_valid) begin
                rr_ptr      <= (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                out_CDB_tag <= sel_entry[ENTRY_W-1 -: TAG_W];
                out_CDB_val <= sel_entry[TOMA_ICC_W +: DATA_W];
                icc_q       <= sel_entry[TOMA_ICC_W-1:0];
            end
            if (|drop) out_drop_err <= 1'b1;
        end
    end

    assign out_ICC_flags = icc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue hand-derived broadcasts
// (with their expected cycle); a negedge monitor pops and compares each broadcast.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [19:0]  in_tag;
    logic [127:0] in_val;
    logic [15:0]  in_icc;
    logic [3:0]   out_ready;
    logic         out_CDB_broadcast;
    logic [4:0]   out_CDB_tag;
    logic [31:0]  out_CDB_val;
    logic [3:0]   out_ICC_flags;
    logic         out_drop_err;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] val;
        logic [3:0]  icc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   c0;

    cdb_arbiter #(
        .NUM_PORTS  (4),
        .TAG_W      (5),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .in_icc            (in_icc),
        .out_ready         (out_ready),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_ICC_flags     (out_ICC_flags),
        .out_drop_err      (out_drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_bc(input logic [4:0] tag, input logic [31:0] val,
                             input logic [3:0] icc, input int at);
        exp_t x;
        x.tag = tag; x.val = val; x.icc = icc; x.cyc = at;
        q.push_back(x);
    endtask

    task automatic drive(input int p, input logic v, input logic [4:0] tag,
                         input logic [31:0] val, input logic [3:0] icc);
        in_valid[p]       = v;
        in_tag[p*5 +: 5]  = tag;
        in_val[p*32 +: 32] = val;
        in_icc[p*4 +: 4]  = icc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk("queue_drained_before_reset", 64'(q.size()), 64'd0);
        in_valid = '0;
        rst_n    = 1'b0;
        #1;
        chk("async_rst_broadcast", 64'(out_CDB_broadcast), 64'd0);
        chk("async_rst_tag", 64'(out_CDB_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_broadcast", 64'(out_CDB_broadcast), 64'd0);
        chk("rst_val", 64'(out_CDB_val), 64'd0);
        chk("rst_icc", 64'(out_ICC_flags), 64'd0);
        chk("rst_drop_err", 64'(out_drop_err), 64'd0);
        chk("rst_ready", 64'(out_ready), 64'hf);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_CDB_broadcast) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_broadcast actual tag=%0h val=%0h required none (cycle %0d)",
                         out_CDB_tag, out_CDB_val, cyc);
            end else begin
                e = q.pop_front();
                chk("bc_tag", 64'(out_CDB_tag), 64'(e.tag));
                chk("bc_val", 64'(out_CDB_val), 64'(e.val));
                chk("bc_icc", 64'(out_ICC_flags), 64'(e.icc));
                chk("bc_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = '0;
        in_tag   = '0;
        in_val   = '0;
        in_icc   = '0;

        // Single result: accept on first edge after reset release, broadcast two edges later.
        do_reset();
        c0 = cyc;
        drive(0, 1'b1, 5'd3, 32'h0000_0010, 4'b0000);
        expect_bc(5'd3, 32'h10, 4'b0000, c0 + 2);
        tick();
        in_valid = '0;
        repeat (4) tick();

        // Contention from rr_ptr=0, then rr_ptr back at 0 picks port 0 before port 3.
        do_reset();
        c0 = cyc;
        for (int p = 0; p < 4; p++) begin
            drive(p, 1'b1, 5'(p), 32'h100 + 32'(p), 4'(p));
            expect_bc(5'(p), 32'h100 + 32'(p), 4'(p), c0 + 2 + p);
        end
        tick();
        in_valid = '0;
        repeat (4) tick();
        drive(0, 1'b1, 5'd7, 32'h700, 4'b1010);
        drive(3, 1'b1, 5'd6, 32'h600, 4'b0101);
        expect_bc(5'd7, 32'h700, 4'b1010, c0 + 7);
        expect_bc(5'd6, 32'h600, 4'b0101, c0 + 8);
        tick();
        in_valid = '0;
        repeat (4) tick();

        // Fairness: port 1 streams, port 2 pushes once and is served next.
        do_reset();
        c0 = cyc;
        drive(1, 1'b1, 5'd8, 32'h8, 4'h1);
        expect_bc(5'd8, 32'h8, 4'h1, c0 + 2);
        tick();
        drive(1, 1'b1, 5'd9, 32'h9, 4'h2);
        drive(2, 1'b1, 5'd30, 32'hdead_beef, 4'hf);
        expect_bc(5'd30, 32'hdead_beef, 4'hf, c0 + 3);
        expect_bc(5'd9, 32'h9, 4'h2, c0 + 4);
        expect_bc(5'd10, 32'ha, 4'h3, c0 + 5);
        expect_bc(5'd11, 32'hb, 4'h4, c0 + 6);
        expect_bc(5'd12, 32'hc, 4'h5, c0 + 7);
        tick();
        drive(2, 1'b0, 5'd0, 32'h0, 4'h0);
        drive(1, 1'b1, 5'd10, 32'ha, 4'h3);
        tick();
        chk("fair_ready1_full", 64'(out_ready[1]), 64'd0);
        drive(1, 1'b1, 5'd11, 32'hb, 4'h4);
        tick();
        chk("fair_ready1_free", 64'(out_ready[1]), 64'd1);
        tick();
        drive(1, 1'b1, 5'd12, 32'hc, 4'h5);
        tick();
        in_valid = '0;
        repeat (4) tick();

        // Backpressure: port 3 fills behind ports 0-2, third result held by producer.
        do_reset();
        c0 = cyc;
        drive(0, 1'b1, 5'd10, 32'h1010, 4'h1);
        drive(1, 1'b1, 5'd11, 32'h1111, 4'h2);
        drive(2, 1'b1, 5'd12, 32'h1212, 4'h3);
        drive(3, 1'b1, 5'd20, 32'h2020, 4'h8);
        expect_bc(5'd10, 32'h1010, 4'h1, c0 + 2);
        expect_bc(5'd11, 32'h1111, 4'h2, c0 + 3);
        expect_bc(5'd12, 32'h1212, 4'h3, c0 + 4);
        expect_bc(5'd20, 32'h2020, 4'h8, c0 + 5);
        expect_bc(5'd21, 32'h2121, 4'h9, c0 + 6);
        expect_bc(5'd22, 32'h2222, 4'hc, c0 + 7);
        tick();
        in_valid[2:0] = '0;
        chk("bp_ready3_one", 64'(out_ready[3]), 64'd1);
        drive(3, 1'b1, 5'd21, 32'h2121, 4'h9);
        tick();
        chk("bp_ready3_full_a", 64'(out_ready[3]), 64'd0);
        drive(3, 1'b1, 5'd22, 32'h2222, 4'hc);
        tick();
        chk("bp_ready3_full_b", 64'(out_ready[3]), 64'd0);
        tick();
        chk("bp_ready3_full_c", 64'(out_ready[3]), 64'd0);
        tick();
        chk("bp_ready3_free", 64'(out_ready[3]), 64'd1);
        tick();
        in_valid = '0;
        repeat (4) tick();

        // Invalid tag: dropped, sticky error, no broadcast.
        do_reset();
        chk("drop_err_clear", 64'(out_drop_err), 64'd0);
        drive(2, 1'b1, 5'h1f, 32'hffff_0000, 4'h7);
        tick();
        in_valid = '0;
        chk("drop_err_set", 64'(out_drop_err), 64'd1);
        repeat (5) tick();
        chk("drop_err_sticky", 64'(out_drop_err), 64'd1);

        // Reset mid-stream: one broadcast pending in flight, three results still queued.
        do_reset();
        c0 = cyc;
        for (int p = 0; p < 4; p++) drive(p, 1'b1, 5'(p + 1), 32'h40 + 32'(p), 4'(p));
        expect_bc(5'd1, 32'h40, 4'h0, c0 + 2);
        tick();
        in_valid = '0;
        tick();
        @(negedge clk);
        #1;
        chk("mid_bc_before_rst", 64'(out_CDB_broadcast), 64'd1);
        do_reset();
        repeat (8) tick();
        chk("queue_drained_final", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of result-producer ports (add RS, mul RS, load/store, logic).
REQ-002 Parameter TAG_W, default 5: tag width; DATA_W, default 32: result width; FIFO_DEPTH, default 2: entries per port.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  NUM_PORTS  per-port result-present strobe.
REQ-006 in_tag  input  NUM_PORTS*TAG_W  per-port result tag; port p occupies bits [p*TAG_W +: TAG_W].
REQ-007 in_val  input  NUM_PORTS*DATA_W  per-port result value, packed the same way.
REQ-008 in_icc  input  NUM_PORTS*4  per-port {c,v,z,n} flags, packed the same way.
REQ-009 out_ready  output  NUM_PORTS  per-port FIFO not full.
REQ-010 out_CDB_broadcast  output  1  CDB valid, one-cycle pulse per result.
REQ-011 out_CDB_tag  output  TAG_W  broadcast tag.
REQ-012 out_CDB_val  output  DATA_W  broadcast value.
REQ-013 out_ICC_flags  output  4  broadcast {c,v,z,n}.
REQ-014 out_drop_err  output  1  sticky; set when an INVALID_TAG result is accepted.

Function
REQ-015 Port p SHALL accept a result on a rising clk edge when in_valid[p] and out_ready[p] are both 1; the accepted result is pushed into FIFO p.
REQ-016 out_ready[p] SHALL be 0 exactly when FIFO p holds FIFO_DEPTH entries; it SHALL NOT depend combinationally on a same-cycle pop.
REQ-017 An accepted result with tag == INVALID_TAG (all ones) SHALL be discarded without entering the FIFO and SHALL set out_drop_err.
REQ-018 Each cycle the arbiter SHALL pop at most one entry, chosen round-robin among non-empty FIFOs, starting at rr_ptr.
REQ-019 After a grant to port k, rr_ptr SHALL become (k+1) mod NUM_PORTS; with no grant it SHALL hold.
REQ-020 The popped entry SHALL appear registered on out_CDB_tag/val/ICC_flags with out_CDB_broadcast=1 on the following cycle; latency from accept to broadcast is 2 cycles minimum (push edge, pop/register edge).
REQ-021 With no grant, out_CDB_broadcast SHALL be 0 next cycle; tag/val/flags SHALL hold their last values.
REQ-022 Simultaneous push and pop on the same FIFO SHALL both take effect; occupancy is unchanged.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; per-port order SHALL be preserved.
REQ-024 A full FIFO SHALL ignore in_valid (out_ready=0); no overwrite and no error.
REQ-025 Sustained throughput SHALL be one broadcast per cycle while any FIFO is non-empty.

Reset
REQ-026 While rst_n=0: all FIFOs empty, rr_ptr=0, out_CDB_broadcast=0, out_CDB_tag=0, out_CDB_val=0, out_ICC_flags=0, out_drop_err=0, out_ready all 1.
REQ-027 Reset asserted mid-operation SHALL discard all queued results and any pending broadcast immediately (asynchronously).
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 INVALID_TAG, TAG_W, DATA_W and the {c,v,z,n} flag ordering SHALL live in the shared tomasulo package used by all reservation stations.
REQ-030 One sub-module, cdb_port_fifo (single-port synchronous FIFO with push/pop/full/empty), SHALL be instantiated NUM_PORTS times.
REQ-031 The round-robin selector and output register SHALL be in cdb_arbiter itself.

Verification
REQ-032 Single result: port 0 pushes tag=3, val=0x0000_0010, icc=4'b0000 at cycle 1 -> broadcast tag=3, val=0x10 at cycle 3 only.
REQ-033 Contention: ports 0..3 push tags 0,1,2,3 same cycle, rr_ptr=0 -> broadcasts tags 0,1,2,3 on four consecutive cycles, then rr_ptr=0.
REQ-034 Fairness: port 1 pushes continuously, port 2 pushes once -> port 2 broadcast within 2 cycles; no port starved.
REQ-035 Backpressure: port 3 pushes 3 results back to back while arbitration is held off by ports 0–2 -> out_ready[3]=0 after 2 accepts, third held by producer and delivered later, order preserved.
REQ-036 Invalid tag: port 2 pushes tag=5'b11111 -> no broadcast, out_drop_err=1 until reset.
REQ-037 Reset mid-stream: rst_n low while 3 entries queued -> out_CDB_broadcast=0 immediately, no queued tag broadcast after release.
